// File: rtl/param_data_source.sv
// Burst data producer: on start, emits COUNT words SEED, SEED+STEP, ... over valid/ready, then pulses done.
// Optional even-parity output enabled by defining DATA_SOURCE_PARITY_EN.
module param_data_source #(
  parameter int unsigned SEED  = 1,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 2,
  parameter int unsigned COUNT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          ready,
  output logic                          valid,
  output logic [WIDTH-1:0]              data,
  output logic                          busy,
  output logic                          done,
`ifdef DATA_SOURCE_PARITY_EN
  output logic                          parity,
`endif
  output logic [$clog2(COUNT+1)-1:0]    sent
);

  // state | meaning
  // IDLE  | waiting for start; outputs quiet, sent holds last burst count
  // SEND  | word on data with valid=1 until accepted; advances by STEP per transfer
  // DONE  | single-cycle done pulse, start ignored
  localparam int unsigned OFFSET = 1;
  localparam int unsigned CW     = $clog2(COUNT + 1);

  localparam logic [WIDTH-OFFSET:0] SEED_T = (WIDTH-OFFSET+1)'(SEED);
  localparam logic [WIDTH-OFFSET:0] STEP_T = (WIDTH-OFFSET+1)'(STEP);
  localparam logic [CW-1:0]         LAST_T = CW'(COUNT - 1);
  localparam logic [CW-1:0]         ONE_T  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-OFFSET:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic [CW-1:0]         sent_q,  sent_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = SEED_T;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          sent_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && ready) begin
          sent_d = sent_q + ONE_T;
          if (sent_q == LAST_T) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // wraps modulo 2^WIDTH by construction of the operand widths
            data_d = data_q + STEP_T;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef DATA_SOURCE_PARITY_EN
  logic parity_q;

  // registered from data_d so it always matches the word currently on data
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= ^data_d;
  end

  assign parity = parity_q;
`endif

  assign valid = valid_q;
  assign data  = data_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sent  = sent_q;

endmodule
